// File: rtl/fetch.sv
// Instruction-fetch stage: program counter, sequential next-PC, and a
// combinationally read, word-addressed instruction ROM.
//
// Ports
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous, active-high; loads RESET_PC
//   instruction  out  32  ROM word at pc_current[AW+1:2]
//   pc_next      out  32  pc_current + 4, carry discarded
//   pc_current   out  32  registered program counter
//
// Parameters
//   RESET_PC    PC loaded on reset (word aligned)
//   MEM_DEPTH   ROM depth in 32-bit words (power of 2, >= 2)
//   MEM_FILE    hex image name (kept for interface compatibility)
//   BOOT_N      number of BOOT_WORDS entries placed at ROM words 0..BOOT_N-1
//   BOOT_WORDS  inline image applied over the zero fill
module fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MEM_DEPTH       = 256,
    parameter              MEM_FILE        = "instructions.mem",
    parameter int          BOOT_N          = 0,
    parameter logic [31:0] BOOT_WORDS [8]  = '{default: 32'h0}
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instruction,
    output logic [31:0] pc_next,
    output logic [31:0] pc_current
);

    localparam int AW = $clog2(MEM_DEPTH);

    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("fetch: RESET_PC must be word aligned");
    end
    if (MEM_DEPTH < 2 || (1 << AW) != MEM_DEPTH) begin : g_bad_depth
        $error("fetch: MEM_DEPTH must be a power of 2 and >= 2");
    end
    if (BOOT_N < 0 || BOOT_N > 8) begin : g_bad_boot
        $error("fetch: BOOT_N must be in 0..8");
    end

    logic [31:0]   r_pc;
    logic [31:0]   r_rom [MEM_DEPTH];
    logic [31:0]   w_pc_next;
    logic [AW-1:0] w_idx;

    // Zero fill first so words the image does not cover read as 0.
    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) begin
            r_rom[i] = 32'h0;
        end
        for (int i = 0; i < BOOT_N && i < MEM_DEPTH; i++) begin
            r_rom[i] = BOOT_WORDS[i];
        end
    end

    // 32-bit add: the carry out of FFFF_FFFC + 4 is dropped, wrapping to 0.
    assign w_pc_next = r_pc + 32'd4;

    // Upper PC bits are ignored, so fetches wrap modulo MEM_DEPTH words.
    assign w_idx = r_pc[AW+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc_current  = r_pc;
    assign pc_next     = w_pc_next;
    assign instruction = r_rom[w_idx];

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: the stimulus process pushes expected values
// per clock edge; a negedge monitor pops and compares both DUT instances.
module tb_fetch;

    localparam logic [31:0] RA  = 32'h0000_0000;
    localparam logic [31:0] RB  = 32'hFFFF_FFF8;
    localparam int          DA  = 256;
    localparam int          DB  = 16;
    localparam logic [31:0] W0  = 32'h0000_0013;
    localparam logic [31:0] W1  = 32'h0010_0093;
    localparam logic [31:0] W2  = 32'h0020_0113;
    localparam logic [31:0] IMG [8] = '{W0, W1, W2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ins_a, nxt_a, pc_a;
    logic [31:0] ins_b, nxt_b, pc_b;

    always #5 clk = ~clk;

    fetch #(
        .RESET_PC   (RA),
        .MEM_DEPTH  (DA),
        .MEM_FILE   (""),
        .BOOT_N     (3),
        .BOOT_WORDS (IMG)
    ) u_a (
        .clk         (clk),
        .reset       (reset),
        .instruction (ins_a),
        .pc_next     (nxt_a),
        .pc_current  (pc_a)
    );

    fetch #(
        .RESET_PC   (RB),
        .MEM_DEPTH  (DB),
        .MEM_FILE   (""),
        .BOOT_N     (3),
        .BOOT_WORDS (IMG)
    ) u_b (
        .clk         (clk),
        .reset       (reset),
        .instruction (ins_b),
        .pc_next     (nxt_b),
        .pc_current  (pc_b)
    );

    typedef struct {
        string       tag;
        logic [31:0] pca;
        logic [31:0] nxa;
        logic [31:0] ina;
        logic [31:0] pcb;
        logic [31:0] nxb;
        logic [31:0] inb;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] m_pa;
    logic [31:0] m_pb;

    // ROM model: image words 0..2, zeros elsewhere, index wraps mod depth.
    function automatic logic [31:0] rom_model(logic [31:0] pc, int depth);
        int idx;
        idx = int'((pc >> 2) % depth);
        case (idx)
            0:       return W0;
            1:       return W1;
            2:       return W2;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(string tag, string fld, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", tag, fld, act, exp);
        end
    endtask

    // One clock edge. With hand=1 the hand-computed PCs are the expectation;
    // otherwise the reference model advances them.
    task automatic step(string tag, logic rst, bit hand,
                        logic [31:0] hpa, logic [31:0] hpb);
        exp_t e;
        @(negedge clk);
        reset = rst;
        @(posedge clk);
        #1;
        if (hand) begin
            m_pa = hpa;
            m_pb = hpb;
        end else if (rst) begin
            m_pa = RA;
            m_pb = RB;
        end else begin
            m_pa = m_pa + 32'd4;
            m_pb = m_pb + 32'd4;
        end
        e.tag = tag;
        e.pca = m_pa;
        e.nxa = m_pa + 32'd4;
        e.ina = rom_model(m_pa, DA);
        e.pcb = m_pb;
        e.nxb = m_pb + 32'd4;
        e.inb = rom_model(m_pb, DB);
        q.push_back(e);
    endtask

    // Directed step with fully hand-written expected outputs for instance A.
    task automatic step_hand(string tag, logic rst,
                             logic [31:0] pa, logic [31:0] na, logic [31:0] ia,
                             logic [31:0] pb);
        step(tag, rst, 1'b1, pa, pb);
        q[q.size()-1].nxa = na;
        q[q.size()-1].ina = ia;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.tag, "pc_a",  pc_a,  e.pca);
            chk(e.tag, "nxt_a", nxt_a, e.nxa);
            chk(e.tag, "ins_a", ins_a, e.ina);
            chk(e.tag, "pc_b",  pc_b,  e.pcb);
            chk(e.tag, "nxt_b", nxt_b, e.nxb);
            chk(e.tag, "ins_b", ins_b, e.inb);
        end
    end

    initial begin
        int budget;
        m_pa = RA;
        m_pb = RB;

        // Reset held for two edges.
        step_hand("rst0", 1'b1, 32'h0, 32'h4, W0, RB);
        step_hand("rst1", 1'b1, 32'h0, 32'h4, W0, RB);

        // Release: A steps 4/8/12; B wraps FFFF_FFFC -> 0 -> 4.
        step_hand("run1", 1'b0, 32'h4, 32'h8,  W1,    32'hFFFF_FFFC);
        step_hand("run2", 1'b0, 32'h8, 32'hC,  W2,    32'h0000_0000);
        step_hand("run3", 1'b0, 32'hC, 32'h10, 32'h0, 32'h0000_0004);

        // Complete ten running cycles, then a one-edge reset mid-program.
        for (int i = 0; i < 7; i++) step("run", 1'b0, 1'b0, 32'h0, 32'h0);
        step_hand("midrst", 1'b1, 32'h0, 32'h4, W0, RB);
        step_hand("resume", 1'b0, 32'h4, 32'h8, W1, 32'hFFFF_FFFC);

        // MEM_DEPTH cycles from reset: PC = 4*DA, fetch wraps to word 0.
        for (int i = 0; i < DA - 2; i++) step("wrap", 1'b0, 1'b0, 32'h0, 32'h0);
        step_hand("romwrap", 1'b0, 32'd1024, 32'd1028, W0, RB + 32'd4 * DA);

        budget = 10;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(posedge clk);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
